// File: rtl/inst_rom_resp_pkg.sv
// Shared definitions for the instruction ROM responder: bus widths, word
// constants and the responder state encoding.
package inst_rom_resp_pkg;

    localparam int unsigned INST_ADDR_W       = 32;
    localparam int unsigned INST_W            = 32;
    localparam int unsigned INST_MEM_NUM_LOG2 = 10;

    localparam logic [INST_W-1:0] ZERO_WORD   = 32'h0000_0000;
    localparam logic              CHIP_ENABLE = 1'b1;

    // LOAD: boot image being written; IDLE: serving held word; BUSY: waiting out wait states
    typedef enum logic [1:0] {
        ROM_LOAD = 2'd0,
        ROM_IDLE = 2'd1,
        ROM_BUSY = 2'd2
    } rom_state_e;

endpackage

// File: rtl/inst_rom_resp_mem.sv
// Single-port synchronous instruction RAM with a registered, read-enabled
// output. The output register doubles as the responder's held data word.
module inst_rom_resp_mem #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Array write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read data only moves when a read is issued
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    // Read data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: boot-loads an on-chip RAM over valid/ready,
// then serves core fetches with a programmable number of wait states.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = INST_MEM_NUM_LOG2,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rom_ce_i,
    input  logic [INST_ADDR_W-1:0] rom_addr_i,
    output logic [INST_W-1:0]      rom_data_o,
    output logic                   rom_stall_o,
    input  logic                   load_valid_i,
    output logic                   load_ready_o,
    input  logic [INST_W-1:0]      load_data_i,
    input  logic                   load_last_i,
    output logic                   load_done_o
);

    localparam int unsigned KEY_W = DEPTH_LOG2 + 1;
    localparam int unsigned CNT_W = 4;
    // The cycle that accepts a new address is itself a stall cycle, so the
    // BUSY countdown covers the remaining WAIT_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [DEPTH_LOG2-1:0] WPTR_LAST = '1;
    localparam logic [KEY_W-1:0]      OOR_KEY   = {1'b1, {DEPTH_LOG2{1'b0}}};

    if (WAIT_CYCLES > 15) begin : g_wait_range
        $error("inst_rom_resp: WAIT_CYCLES must be in 0..15");
    end

    rom_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic                  held_valid_q, held_valid_d;
    logic [KEY_W-1:0]      held_key_q, held_key_d;
    logic [KEY_W-1:0]      cap_key_q, cap_key_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;

    logic                  ce;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  req_oor;
    logic [KEY_W-1:0]      req_key;
    logic                  new_req;
    logic                  stall_c;
    logic                  mem_we;
    logic                  mem_re;
    logic [DEPTH_LOG2-1:0] mem_addr;
    logic [INST_W-1:0]     mem_rdata;

    wire unused_addr_lsbs = &{1'b0, rom_addr_i[1:0]};

    // Request decode: out-of-range addresses collapse onto one distinct key
    always_comb begin
        ce      = (rom_ce_i == CHIP_ENABLE);
        req_idx = rom_addr_i[DEPTH_LOG2+1:2];
        req_oor = |rom_addr_i[INST_ADDR_W-1:DEPTH_LOG2+2];
        req_key = req_oor ? OOR_KEY : {1'b0, req_idx};
        new_req = ce && (!held_valid_q || (req_key != held_key_q));
    end

    // Next-state, RAM port arbitration and stall generation
    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        held_valid_d = held_valid_q;
        held_key_d   = held_key_q;
        cap_key_d    = cap_key_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = wptr_q;
        stall_c      = 1'b0;

        case (state_q)
            ROM_LOAD: begin
                stall_c = ce;
                if (load_valid_i && load_ready_o) begin
                    mem_we = 1'b1;
                    wptr_d = wptr_q + 1'b1;
                    if (load_last_i || (wptr_q == WPTR_LAST)) begin
                        state_d = ROM_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ROM_IDLE: begin
                if (new_req) begin
                    stall_c = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        mem_re       = 1'b1;
                        mem_addr     = req_idx;
                        held_key_d   = req_key;
                        held_valid_d = 1'b1;
                    end else begin
                        cap_key_d = req_key;
                        cnt_d     = CNT_LOAD;
                        state_d   = ROM_BUSY;
                    end
                end
            end
            ROM_BUSY: begin
                stall_c = ce;
                if (!ce) begin
                    state_d = ROM_IDLE;
                end else if (req_key != cap_key_q) begin
                    cap_key_d = req_key;
                    cnt_d     = CNT_LOAD;
                end else if (cnt_q == '0) begin
                    mem_re       = 1'b1;
                    mem_addr     = cap_key_q[DEPTH_LOG2-1:0];
                    held_key_d   = cap_key_q;
                    held_valid_d = 1'b1;
                    state_d      = ROM_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ROM_LOAD;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ROM_LOAD;
            wptr_q       <= '0;
            held_valid_q <= 1'b0;
            held_key_q   <= '0;
            cap_key_q    <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            held_valid_q <= held_valid_d;
            held_key_q   <= held_key_d;
            cap_key_q    <= cap_key_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
        end
    end

    inst_rom_resp_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (INST_W)
    ) u_inst_mem_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr),
        .wdata_i (load_data_i),
        .rdata_o (mem_rdata)
    );

    // Core-facing outputs; zero word when disabled or out of range
    always_comb begin
        load_ready_o = (state_q == ROM_LOAD) && !rst;
        load_done_o  = done_q;
        rom_stall_o  = stall_c && !rst;
        rom_data_o   = (ce && !held_key_q[DEPTH_LOG2]) ? mem_rdata : ZERO_WORD;
    end

endmodule

// File: tb/tb_inst_rom_resp.sv
// Directed bench for inst_rom_resp (DEPTH_LOG2=10, WAIT_CYCLES=1).
module tb_inst_rom_resp;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data_o;
    logic        rom_stall_o;
    logic        load_valid;
    logic        load_ready_o;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_done_o;

    int n_tests = 0;
    int n_fail  = 0;

    inst_rom_resp #(
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_ce_i     (rom_ce),
        .rom_addr_i   (rom_addr),
        .rom_data_o   (rom_data_o),
        .rom_stall_o  (rom_stall_o),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .load_done_o  (load_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        cyc();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Present an address and count stall cycles until data is offered
    task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                         input int exp_stall, input string tag);
        int n;
        rom_ce   = 1'b1;
        rom_addr = addr;
        #1;
        n = 0;
        while (rom_stall_o && n < 20) begin
            cyc();
            #1;
            n++;
        end
        chk({tag, "_stall"}, 32'(n), 32'(exp_stall));
        chk({tag, "_data"}, rom_data_o, exp_data);
    endtask

    logic [31:0] boot [4];

    initial begin
        boot[0] = 32'h3401_1100;
        boot[1] = 32'h3402_0020;
        boot[2] = 32'h3403_ff00;
        boot[3] = 32'h3404_ffff;

        rst        = 1'b1;
        rom_ce     = 1'b1;
        rom_addr   = 32'h0;
        load_valid = 1'b0;
        load_data  = 32'h0;
        load_last  = 1'b0;
        #12;
        chk("rst_data",  32'(rom_data_o),   32'h0);
        chk("rst_stall", 32'(rom_stall_o),  32'h0);
        chk("rst_ready", 32'(load_ready_o), 32'h0);
        chk("rst_done",  32'(load_done_o),  32'h0);
        cyc();
        rst = 1'b0;
        #1;

        // Boot load with core already fetching
        for (int i = 0; i < 4; i++) begin
            chk("load_ready", 32'(load_ready_o), 32'h1);
            chk("load_stall", 32'(rom_stall_o),  32'h1);
            chk("load_done0", 32'(load_done_o),  32'h0);
            load_word(boot[i], (i == 3));
        end
        chk("load_done",   32'(load_done_o),  32'h1);
        chk("load_ready0", 32'(load_ready_o), 32'h0);

        // Wait-state and pipelined fetches
        fetch(32'h0, boot[0], 2, "f0");
        cyc();
        fetch(32'h0, boot[0], 0, "f0_hold");
        fetch(32'h4, boot[1], 2, "f4");
        fetch(32'h8, boot[2], 2, "f8");
        fetch(32'h5, boot[1], 2, "f5");
        fetch(32'h4, boot[1], 0, "f4_same_idx");

        // Address change mid-BUSY abandons the old request
        fetch(32'h0, boot[0], 2, "f0_again");
        rom_addr = 32'h4;
        #1;
        chk("abort_stall_a", 32'(rom_stall_o), 32'h1);
        cyc();
        chk("abort_stall_b", 32'(rom_stall_o), 32'h1);
        fetch(32'hC, boot[3], 2, "abort_fc");

        rom_ce = 1'b0;
        #1;
        chk("ce0_data",  rom_data_o,          32'h0);
        chk("ce0_stall", 32'(rom_stall_o),    32'h0);

        // Chip-enable drop mid-BUSY keeps the previously held word
        rom_ce   = 1'b1;
        rom_addr = 32'h8;
        #1;
        chk("drop_stall", 32'(rom_stall_o), 32'h1);
        cyc();
        rom_ce = 1'b0;
        cyc();
        fetch(32'hC, boot[3], 0, "drop_held");

        // Out-of-range fetches
        fetch(32'h0000_1000, 32'h0, 2, "oor_1000");
        fetch(32'h0000_2000, 32'h0, 0, "oor_same");
        fetch(32'h8, boot[2], 2, "oor_back");

        // Extra load words after done are ignored
        load_word(32'hbad0_bad0, 1'b1);
        chk("extra_done", 32'(load_done_o), 32'h1);

        // Asynchronous reset in the middle of a fetch
        fetch(32'h0, boot[0], 2, "pre_rst");
        rom_addr = 32'h4;
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_data",  rom_data_o,          32'h0);
        chk("mid_rst_stall", 32'(rom_stall_o),    32'h0);
        chk("mid_rst_done",  32'(load_done_o),    32'h0);
        cyc();
        rst = 1'b0;
        #1;
        chk("reload_ready", 32'(load_ready_o), 32'h1);
        load_word(32'hdead_beef, 1'b1);
        chk("reload_done", 32'(load_done_o), 32'h1);
        fetch(32'h0, 32'hdead_beef, 2, "reload_w0");
        fetch(32'h4, boot[1], 2, "retain_w1");
        fetch(32'hC, boot[3], 2, "retain_w3");

        // Full-depth load terminates without last
        rst = 1'b1;
        cyc();
        rst    = 1'b0;
        rom_ce = 1'b0;
        #1;
        for (int i = 0; i < 1024; i++) begin
            if (i == 1023) begin
                chk("full_ready", 32'(load_ready_o), 32'h1);
                chk("full_done0", 32'(load_done_o),  32'h0);
            end
            load_word(32'h1000_0000 + 32'(i), 1'b0);
        end
        chk("full_done",   32'(load_done_o),  32'h1);
        chk("full_ready0", 32'(load_ready_o), 32'h0);
        fetch(32'hFFC, 32'h1000_03ff, 2, "full_last");
        fetch(32'h0,   32'h1000_0000, 2, "full_first");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
